// File: rtl/u712_pkg.sv
// u712_pkg: shared size encodings, sequencer states and default timeout
package u712_pkg;
  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_BYTE = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;
  localparam logic [1:0] SIZ_LINE = 2'b11;
  localparam int TIMEOUT_DEF = 255;
  typedef enum logic [2:0] {IDLE, REQ, HALF, TA, ERR} state_t;
endpackage

// File: rtl/u712_chip_cycle_sequencer_if.sv
// u712_chip_cycle_sequencer_if: CPU transfer inputs, chipset handshake and byte-enable feed of the sequencer
interface u712_chip_cycle_sequencer_if;
  logic TSn;
  logic [3:0] A_CPU;
  logic [1:0] SIZ_CPU;
  logic CHIP_SEL;
  logic CHIP_ACK;
  logic CHIP_ERR;
  logic [3:0] A_OUT;
  logic [1:0] SIZ_OUT;
  logic CPU_CYCLE;
  logic CHIP_REQ;
  logic TAn;
  logic TEAn;
  logic BUSY;
  modport master (
    input TSn, A_CPU, SIZ_CPU, CHIP_SEL, CHIP_ACK, CHIP_ERR,
    output A_OUT, SIZ_OUT, CPU_CYCLE, CHIP_REQ, TAn, TEAn, BUSY
  );
  modport slave (
    output TSn, A_CPU, SIZ_CPU, CHIP_SEL, CHIP_ACK, CHIP_ERR,
    input A_OUT, SIZ_OUT, CPU_CYCLE, CHIP_REQ, TAn, TEAn, BUSY
  );
endinterface

// File: rtl/u712_cycle_timeout.sv
// u712_cycle_timeout: counts enabled clocks since clear, expired on the clock that reaches TIMEOUT
module u712_cycle_timeout #(
  parameter int TIMEOUT = 255,
  parameter int TO_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [TO_W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : en ? cnt + 1'b1 : cnt;
  assign expired = en && cnt == TO_W'(TIMEOUT - 1);
endmodule

// File: rtl/u712_chip_cycle_sequencer.sv
// u712_chip_cycle_sequencer: splits 68040 transfers into 16-bit chipset cycles and returns TAn/TEAn per longword
module u712_chip_cycle_sequencer
  import u712_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W = 8
) (
  input logic CLK40,
  input logic RESET,
  u712_chip_cycle_sequencer_if.master bus
);
  state_t state, nx;
  logic two, line, expired;
  logic [1:0] beat;
  u712_cycle_timeout #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_timeout (
    .clk(CLK40),
    .rst(RESET),
    .clr(state != REQ),
    .en(state == REQ),
    .expired(expired)
  );
  always_comb begin
    nx = state;
    case (state)
      IDLE: nx = (!bus.TSn && bus.CHIP_SEL) ? REQ : IDLE;
      REQ: nx = (bus.CHIP_ERR || expired) ? ERR : !bus.CHIP_ACK ? REQ : (two && !bus.A_OUT[1]) ? HALF : TA;
      HALF: nx = REQ;
      TA: nx = (line && beat != 2'd3) ? REQ : IDLE;
      default: nx = IDLE;
    endcase
  end
  always_ff @(posedge CLK40) begin
    if (RESET) begin
      state <= IDLE;
      bus.A_OUT <= '0;
      bus.SIZ_OUT <= '0;
      bus.CPU_CYCLE <= 1'b0;
      bus.CHIP_REQ <= 1'b0;
      bus.TAn <= 1'b1;
      bus.TEAn <= 1'b1;
      bus.BUSY <= 1'b0;
      two <= 1'b0;
      line <= 1'b0;
      beat <= '0;
    end else begin
      state <= nx;
      bus.CPU_CYCLE <= nx != IDLE;
      bus.BUSY <= nx != IDLE;
      bus.CHIP_REQ <= nx == REQ;
      bus.TAn <= nx != TA;
      bus.TEAn <= nx != ERR;
      if (state == IDLE && nx == REQ) begin
        two <= bus.SIZ_CPU == SIZ_LONG || bus.SIZ_CPU == SIZ_LINE;
        line <= bus.SIZ_CPU == SIZ_LINE;
        beat <= '0;
        bus.SIZ_OUT <= bus.SIZ_CPU == SIZ_BYTE ? SIZ_BYTE : SIZ_WORD;
        bus.A_OUT <= bus.SIZ_CPU == SIZ_BYTE ? bus.A_CPU :
                     bus.SIZ_CPU == SIZ_WORD ? {bus.A_CPU[3:1], 1'b0} : {bus.A_CPU[3:2], 2'b00};
      end
      if (state == HALF)
        bus.A_OUT[1] <= 1'b1;
      if (state == TA) begin
        beat <= beat + 1'b1;
        if (nx == REQ)
          bus.A_OUT <= {bus.A_OUT[3:2] + 2'd1, 2'b00};
      end
    end
  end
endmodule

// File: tb/tb_u712_chip_cycle_sequencer.sv
// tb_u712_chip_cycle_sequencer: directed checks of byte, long, line, error, timeout and reset sequences
module tb_u712_chip_cycle_sequencer;
  import u712_pkg::*;
  logic CLK40 = 1'b0;
  logic RESET = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int ta_cnt = 0;
  int req_rise = 0;
  int t0, r0;
  logic req_q = 1'b0;
  logic [3:0] la [8];
  u712_chip_cycle_sequencer_if bus ();
  u712_chip_cycle_sequencer #(.TIMEOUT(4), .TO_W(8)) dut (
    .CLK40(CLK40),
    .RESET(RESET),
    .bus(bus)
  );
  always #5 CLK40 = ~CLK40;
  always @(negedge CLK40) begin
    if (bus.TAn === 1'b0) ta_cnt++;
    if (bus.CHIP_REQ === 1'b1 && req_q !== 1'b1) req_rise++;
    req_q = bus.CHIP_REQ;
  end
  function automatic logic [10:0] pk();
    return {bus.A_OUT, bus.SIZ_OUT, bus.CPU_CYCLE, bus.CHIP_REQ, bus.TAn, bus.TEAn, bus.BUSY};
  endfunction
  function automatic logic [10:0] x(state_t st, logic [3:0] a, logic [1:0] z);
    return {a, z, st != IDLE, st == REQ, st != TA, st != ERR, st != IDLE};
  endfunction
  task automatic cyc();
    @(posedge CLK40);
    #1;
  endtask
  task automatic chk(input string tag, input logic [10:0] exp);
    n_chk++;
    assert (pk() === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, pk(), exp);
    end
  endtask
  task automatic chkv(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [3:0] a, input logic [1:0] z);
    bus.TSn = 1'b0;
    bus.CHIP_SEL = 1'b1;
    bus.A_CPU = a;
    bus.SIZ_CPU = z;
    cyc();
    bus.TSn = 1'b1;
    bus.CHIP_SEL = 1'b0;
  endtask
  task automatic ack(input string tag, input logic [3:0] a, input logic [1:0] z);
    chk(tag, x(REQ, a, z));
    bus.CHIP_ACK = 1'b1;
    cyc();
    bus.CHIP_ACK = 1'b0;
  endtask
  initial begin
    la = '{4'h8, 4'hA, 4'hC, 4'hE, 4'h0, 4'h2, 4'h4, 4'h6};
    bus.TSn = 1'b1;
    bus.CHIP_SEL = 1'b0;
    bus.A_CPU = '0;
    bus.SIZ_CPU = '0;
    bus.CHIP_ACK = 1'b0;
    bus.CHIP_ERR = 1'b0;
    repeat (2) cyc();
    RESET = 1'b0;
    chk("reset", x(IDLE, 4'h0, 2'b00));
    bus.CHIP_ACK = 1'b1;
    cyc();
    bus.CHIP_ACK = 1'b0;
    chk("ack_idle", x(IDLE, 4'h0, 2'b00));
    t0 = ta_cnt; r0 = req_rise;
    start(4'h3, SIZ_BYTE);
    chk("byte_req", x(REQ, 4'h3, SIZ_BYTE));
    cyc();
    cyc();
    ack("byte_hold", 4'h3, SIZ_BYTE);
    chk("byte_ta", x(TA, 4'h3, SIZ_BYTE));
    cyc();
    chk("byte_idle", x(IDLE, 4'h3, SIZ_BYTE));
    chkv("byte_ta_cnt", ta_cnt - t0, 1);
    chkv("byte_req_cnt", req_rise - r0, 1);
    t0 = ta_cnt; r0 = req_rise;
    start(4'h4, SIZ_LONG);
    ack("long_a0", 4'h4, SIZ_WORD);
    chk("long_gap", x(HALF, 4'h4, SIZ_WORD));
    cyc();
    ack("long_a1", 4'h6, SIZ_WORD);
    chk("long_ta", x(TA, 4'h6, SIZ_WORD));
    cyc();
    chk("long_idle", x(IDLE, 4'h6, SIZ_WORD));
    chkv("long_ta_cnt", ta_cnt - t0, 1);
    chkv("long_req_cnt", req_rise - r0, 2);
    t0 = ta_cnt; r0 = req_rise;
    start(4'h8, SIZ_LINE);
    for (int b = 0; b < 4; b++) begin
      ack("line_req_lo", la[2*b], SIZ_WORD);
      chk("line_half", x(HALF, la[2*b], SIZ_WORD));
      cyc();
      ack("line_req_hi", la[2*b+1], SIZ_WORD);
      chk("line_ta", x(TA, la[2*b+1], SIZ_WORD));
      cyc();
    end
    chk("line_idle", x(IDLE, 4'h6, SIZ_WORD));
    chkv("line_ta_cnt", ta_cnt - t0, 4);
    chkv("line_req_cnt", req_rise - r0, 8);
    t0 = ta_cnt; r0 = req_rise;
    start(4'h0, SIZ_LINE);
    ack("err_a0", 4'h0, SIZ_WORD);
    chk("err_half", x(HALF, 4'h0, SIZ_WORD));
    cyc();
    ack("err_a1", 4'h2, SIZ_WORD);
    chk("err_ta", x(TA, 4'h2, SIZ_WORD));
    cyc();
    chk("err_req3", x(REQ, 4'h4, SIZ_WORD));
    bus.CHIP_ERR = 1'b1;
    cyc();
    bus.CHIP_ERR = 1'b0;
    chk("err_tea", x(ERR, 4'h4, SIZ_WORD));
    cyc();
    chk("err_idle", x(IDLE, 4'h4, SIZ_WORD));
    repeat (4) cyc();
    chkv("err_ta_cnt", ta_cnt - t0, 1);
    chkv("err_req_cnt", req_rise - r0, 3);
    start(4'h1, SIZ_BYTE);
    chk("ackerr_req", x(REQ, 4'h1, SIZ_BYTE));
    bus.CHIP_ACK = 1'b1;
    bus.CHIP_ERR = 1'b1;
    cyc();
    bus.CHIP_ACK = 1'b0;
    bus.CHIP_ERR = 1'b0;
    chk("ackerr_tea", x(ERR, 4'h1, SIZ_BYTE));
    cyc();
    chk("ackerr_idle", x(IDLE, 4'h1, SIZ_BYTE));
    r0 = req_rise;
    start(4'h5, SIZ_BYTE);
    bus.TSn = 1'b0;
    bus.CHIP_SEL = 1'b1;
    bus.A_CPU = 4'hF;
    bus.SIZ_CPU = SIZ_LONG;
    chk("to_req0", x(REQ, 4'h5, SIZ_BYTE));
    repeat (3) begin
      cyc();
      chk("to_req", x(REQ, 4'h5, SIZ_BYTE));
    end
    cyc();
    chk("to_tea", x(ERR, 4'h5, SIZ_BYTE));
    cyc();
    bus.TSn = 1'b1;
    bus.CHIP_SEL = 1'b0;
    chk("to_idle", x(IDLE, 4'h5, SIZ_BYTE));
    cyc();
    chk("to_no_capture", x(IDLE, 4'h5, SIZ_BYTE));
    chkv("to_req_cnt", req_rise - r0, 1);
    t0 = ta_cnt;
    start(4'h4, SIZ_LONG);
    ack("rst_a0", 4'h4, SIZ_WORD);
    chk("rst_half", x(HALF, 4'h4, SIZ_WORD));
    cyc();
    chk("rst_req1", x(REQ, 4'h6, SIZ_WORD));
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    chk("rst_mid", x(IDLE, 4'h0, 2'b00));
    cyc();
    chk("rst_after", x(IDLE, 4'h0, 2'b00));
    chkv("rst_ta_cnt", ta_cnt - t0, 0);
    t0 = ta_cnt;
    start(4'h7, SIZ_WORD);
    ack("word_req", 4'h6, SIZ_WORD);
    chk("word_ta", x(TA, 4'h6, SIZ_WORD));
    cyc();
    chk("word_idle", x(IDLE, 4'h6, SIZ_WORD));
    chkv("word_ta_cnt", ta_cnt - t0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
